mem_arbiter: RTL

//  Shares one memory port between instruction fetch (imem) and data access (dmem, driven by decode_stage).

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (imem) and data (dmem) share one memory port.
// Optional MEM_ARB_FAIR_EN swaps fixed dmem>imem priority for round-robin.

module mem_arb_req_buf #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              instr,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN/8-1:0] wstrb,
   input  logic              clr,
   output logic              full,
   output logic              q_instr,
   output logic [XLEN-1:0]   q_addr,
   output logic [XLEN-1:0]   q_wdata,
   output logic [XLEN/8-1:0] q_wstrb
);
   // One outstanding request per side: a strobe while full is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full    <= 1'b0;
         q_instr <= 1'b0;
         q_addr  <= '0;
         q_wdata <= '0;
         q_wstrb <= '0;
      end else if (clr) begin
         full <= 1'b0;
      end else if (valid && !full) begin
         full    <= 1'b1;
         q_instr <= instr;
         q_addr  <= addr;
         q_wdata <= wdata;
         q_wstrb <= wstrb;
      end
   end
endmodule

module mem_arbiter #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_valid,
   input  logic              imem_instr,
   input  logic [XLEN-1:0]   imem_addr,
   input  logic [XLEN-1:0]   imem_wdata,
   input  logic [XLEN/8-1:0] imem_wstrb,
   output logic              imem_ready,
   output logic [XLEN-1:0]   imem_rdata,
   input  logic              dmem_valid,
   input  logic              dmem_instr,
   input  logic [XLEN-1:0]   dmem_addr,
   input  logic [XLEN-1:0]   dmem_wdata,
   input  logic [XLEN/8-1:0] dmem_wstrb,
   output logic              dmem_ready,
   output logic [XLEN-1:0]   dmem_rdata,
   output logic              mem_valid,
   output logic              mem_instr,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int SW = XLEN/8;
   localparam int SIDE_I = 0;
   localparam int SIDE_D = 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;

   logic [1:0]                v, ins, full, done, eff_pend, eff_ins;
   logic [1:0][XLEN-1:0]      a, wd, q_a, q_wd, eff_a, eff_wd;
   logic [1:0][SW-1:0]        ws, q_ws, eff_ws;
   logic [1:0]                q_ins;
   logic [1:0]                state;
   logic                      fire, pick, any_pend;

   assign v   = {dmem_valid, imem_valid};
   assign ins = {dmem_instr, imem_instr};
   assign a   = {dmem_addr,  imem_addr};
   assign wd  = {dmem_wdata, imem_wdata};
   assign ws  = {dmem_wstrb, imem_wstrb};

   // mem_valid is high exactly while a grant is active
   assign fire    = mem_valid & mem_ready;
   assign done[SIDE_I] = fire & (state == GRANT_I);
   assign done[SIDE_D] = fire & (state == GRANT_D);

   genvar s;
   generate
      for (s = 0; s < 2; s++) begin : g_side
         mem_arb_req_buf #(.XLEN(XLEN)) u_buf (
            .clk     (clk),
            .rst     (rst),
            .valid   (v[s]),
            .instr   (ins[s]),
            .addr    (a[s]),
            .wdata   (wd[s]),
            .wstrb   (ws[s]),
            .clr     (done[s]),
            .full    (full[s]),
            .q_instr (q_ins[s]),
            .q_addr  (q_a[s]),
            .q_wdata (q_wd[s]),
            .q_wstrb (q_ws[s])
         );

         // Pending as seen at this edge: a held request not completing now,
         // or a fresh strobe being captured now (lets grant start at N+1).
         assign eff_pend[s] = (full[s] & ~done[s]) | (v[s] & ~full[s]);
         assign eff_ins[s]  = full[s] ? q_ins[s] : ins[s];
         assign eff_a[s]    = full[s] ? q_a[s]   : a[s];
         assign eff_wd[s]   = full[s] ? q_wd[s]  : wd[s];
         assign eff_ws[s]   = full[s] ? q_ws[s]  : ws[s];
      end
   endgenerate

   assign any_pend = |eff_pend;

`ifdef MEM_ARB_FAIR_EN
   logic last_gnt;

   always_comb begin
      pick = 1'b0;
      if (eff_pend[SIDE_D] && eff_pend[SIDE_I]) pick = ~last_gnt;
      else                                      pick = eff_pend[SIDE_D];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              last_gnt <= 1'(SIDE_I);
      else if ((state == IDLE || fire) && any_pend) last_gnt <= pick;
   end
`else
   always_comb begin
      pick = eff_pend[SIDE_D];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         mem_valid  <= 1'b0;
         mem_instr  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         imem_ready <= 1'b0;
         imem_rdata <= '0;
         dmem_ready <= 1'b0;
         dmem_rdata <= '0;
      end else begin
         imem_ready <= done[SIDE_I];
         dmem_ready <= done[SIDE_D];
         // Writes complete without disturbing the last read data.
         if (done[SIDE_I] && mem_wstrb == '0) imem_rdata <= mem_rdata;
         if (done[SIDE_D] && mem_wstrb == '0) dmem_rdata <= mem_rdata;
         if (state == IDLE || fire) begin
            if (any_pend) begin
               state     <= pick ? GRANT_D : GRANT_I;
               mem_valid <= 1'b1;
               mem_instr <= eff_ins[pick];
               mem_addr  <= eff_a[pick];
               mem_wdata <= eff_wd[pick];
               mem_wstrb <= eff_ws[pick];
            end else begin
               state     <= IDLE;
               mem_valid <= 1'b0;
            end
         end
      end
   end
endmodule
